// File: rtl/altro_rdo_pkg.sv
// Shared types and default constants for the ALTRO channel readout sequencer.
package altro_rdo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_DONE
  } state_t;

  typedef enum logic {
    PASS_HG,
    PASS_LG
  } pass_t;

  localparam int LG_OFS_DEF  = 64;
  localparam int TMO_CYC_DEF = 4096;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter; a clear together with an increment loads 1.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? W'(1) : '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/altro_chrdo_seq.sv
// Channel readout sequencer: walks the channel mask (HG pass, optional LG pass over
// overflowed channels), issuing one request per enabled channel with timeout/abort.
module altro_chrdo_seq
  import altro_rdo_pkg::*;
#(
  parameter int NCH     = 32,
  parameter int CHAW    = 7,
  parameter int LG_OFS  = LG_OFS_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int CNTW    = 16
) (
  input  logic            rdoclk,
  input  logic            reset,
  input  logic            rdo_cmd,
  input  logic            abort_cmd,
  input  logic [NCH-1:0]  chmask,
  input  logic            lgsen,
  input  logic [NCH-1:0]  hgovf,
  input  logic            fifo_almost_full,
  output logic            ch_req,
  output logic [CHAW-1:0] ch_addr,
  input  logic            ch_ack,
  input  logic            ch_err,
  output logic            ovf_clr,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [7:0]      chrd_cnt,
  output logic [CNTW-1:0] err_cnt,
  input  logic            err_clr
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW = $clog2(TMO_CYC + 1);

  state_t          r_state, w_nxt_state;
  pass_t           r_pass, w_nxt_pass;
  logic [IW-1:0]   r_idx, w_nxt_idx;
  logic [NCH-1:0]  r_mask, r_hgovf;
  logic            r_lgsen;
  logic [TW-1:0]   r_tmo;
  logic            r_req, r_busy, r_done, r_ovf_clr, r_aborted;
  logic [CHAW-1:0] r_addr, w_addr;
  logic            w_start, w_snap, w_adv, w_abort, w_acc, w_err_inc;
  logic            w_en, w_last, w_tmo_hit;

  assign w_en      = (r_pass == PASS_HG) ? r_mask[r_idx] : (r_mask[r_idx] & r_hgovf[r_idx]);
  assign w_last    = (r_idx == IW'(NCH - 1));
  assign w_tmo_hit = (r_tmo == TW'(TMO_CYC - 1));
  assign w_addr    = (r_pass == PASS_LG) ? (CHAW'(r_idx) + CHAW'(LG_OFS)) : CHAW'(r_idx);

  always_ff @(posedge rdoclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pass  = r_pass;
    w_nxt_idx   = r_idx;
    w_start     = 1'b0;
    w_snap      = 1'b0;
    w_adv       = 1'b0;
    w_abort     = 1'b0;
    w_acc       = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rdo_cmd && !abort_cmd) begin
          w_start     = 1'b1;
          w_nxt_state = ST_SCAN;
          w_nxt_pass  = PASS_HG;
          w_nxt_idx   = '0;
        end
      end
      ST_SCAN: begin
        if (abort_cmd) begin
          w_abort     = 1'b1;
          w_nxt_state = ST_DONE;
        end else if (w_en) begin
          if (!fifo_almost_full) w_nxt_state = ST_REQ;
        end else begin
          w_adv = 1'b1;
        end
      end
      ST_REQ: begin
        // Abort takes priority: a coincident ack is dropped uncounted.
        if (abort_cmd) begin
          w_abort     = 1'b1;
          w_nxt_state = ST_DONE;
        end else if (ch_ack) begin
          w_acc     = 1'b1;
          w_err_inc = ch_err;
          w_adv     = 1'b1;
        end else if (w_tmo_hit) begin
          w_err_inc = 1'b1;
          w_adv     = 1'b1;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
    if (w_adv) begin
      if (!w_last) begin
        w_nxt_idx   = r_idx + IW'(1);
        w_nxt_state = ST_SCAN;
      end else if ((r_pass == PASS_HG) && r_lgsen) begin
        w_snap      = 1'b1;
        w_nxt_pass  = PASS_LG;
        w_nxt_idx   = '0;
        w_nxt_state = ST_SCAN;
      end else begin
        w_nxt_state = ST_DONE;
      end
    end
  end

  always_ff @(posedge rdoclk) begin
    if (reset) begin
      r_pass    <= PASS_HG;
      r_idx     <= '0;
      r_mask    <= '0;
      r_hgovf   <= '0;
      r_lgsen   <= 1'b0;
      r_tmo     <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf_clr <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_pass <= w_nxt_pass;
      r_idx  <= w_nxt_idx;
      if (w_start) begin
        r_mask  <= chmask;
        r_lgsen <= lgsen;
      end
      if (w_snap) r_hgovf <= hgovf;
      r_tmo <= ((r_state == ST_REQ) && (w_nxt_state == ST_REQ)) ? r_tmo + TW'(1) : '0;
      r_req <= (w_nxt_state == ST_REQ);
      if ((r_state == ST_SCAN) && (w_nxt_state == ST_REQ)) r_addr <= w_addr;
      r_busy    <= (w_nxt_state == ST_SCAN) || (w_nxt_state == ST_REQ);
      r_done    <= (w_nxt_state == ST_DONE);
      r_ovf_clr <= w_start;
      if (w_start) r_aborted <= 1'b0;
      else if (w_abort) r_aborted <= 1'b1;
    end
  end

  sat_cnt #(.W(CNTW)) u_err_cnt (
    .i_clk (rdoclk),
    .i_rst (reset),
    .i_inc (w_err_inc),
    .i_clr (err_clr),
    .o_cnt (err_cnt)
  );

  sat_cnt #(.W(8)) u_chrd_cnt (
    .i_clk (rdoclk),
    .i_rst (reset),
    .i_inc (w_acc),
    .i_clr (w_start),
    .o_cnt (chrd_cnt)
  );

  assign ch_req  = r_req;
  assign ch_addr = r_addr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf_clr = r_ovf_clr;
  assign aborted = r_aborted;

endmodule

// File: tb/tb_altro_chrdo_seq.sv
// Self-checking bench for altro_chrdo_seq: expected request addresses are queued from a
// mask/overflow model at start and popped as the DUT raises each request.
module tb_altro_chrdo_seq;

  localparam int NCH     = 32;
  localparam int CHAW    = 7;
  localparam int LG_OFS  = 64;
  localparam int TMO     = 16;
  localparam int CNTW    = 8;
  localparam int ERR_MAX = 255;

  logic            clk = 1'b0;
  logic            reset, rdo_cmd, abort_cmd, lgsen, fifo_almost_full;
  logic [NCH-1:0]  chmask, hgovf;
  logic            ch_req, ch_ack, ch_err, ovf_clr, busy, done, aborted, err_clr;
  logic [CHAW-1:0] ch_addr;
  logic [7:0]      chrd_cnt;
  logic [CNTW-1:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  altro_chrdo_seq #(
    .NCH(NCH), .CHAW(CHAW), .LG_OFS(LG_OFS), .TMO_CYC(TMO), .CNTW(CNTW)
  ) dut (
    .rdoclk(clk), .reset(reset), .rdo_cmd(rdo_cmd), .abort_cmd(abort_cmd),
    .chmask(chmask), .lgsen(lgsen), .hgovf(hgovf), .fifo_almost_full(fifo_almost_full),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack), .ch_err(ch_err),
    .ovf_clr(ovf_clr), .busy(busy), .done(done), .aborted(aborted),
    .chrd_cnt(chrd_cnt), .err_cnt(err_cnt), .err_clr(err_clr)
  );

  task automatic test_reset();
    reset = 1'b1; rdo_cmd = 1'b0; abort_cmd = 1'b0; lgsen = 1'b0; fifo_almost_full = 1'b0;
    chmask = '0; hgovf = '0; ch_ack = 1'b0; ch_err = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ch_req, ch_addr, ovf_clr, busy, done, aborted, chrd_cnt, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: req=%0b addr=%0d ovf_clr=%0b busy=%0b done=%0b abt=%0b chrd=%0d err=%0d, all required 0",
               ch_req, ch_addr, ovf_clr, busy, done, aborted, chrd_cnt, err_cnt);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one sequence. noack: address never acked (times out); abort_req: ordinal of the
  // request that gets abort+ack together (0 = none); exp_first/exp_done: cycle numbers
  // counted from the rdo_cmd cycle (0 = not checked).
  task automatic run_seq(input string name, input logic [NCH-1:0] mask, input logic lgs,
                         input logic [NCH-1:0] hov, input int noack, input logic err,
                         input int af_from, input int af_len, input int abort_req,
                         input logic clr_on_tmo, input int exp_first, input int exp_done);
    int   c, nreq, req_len, req_addr, first_c, done_c, exp_chrd, exp_v;
    logic prev_req, ab;
    exp_q.delete();
    for (int i = 0; i < NCH; i++) if (mask[i]) exp_q.push_back(i);
    if (lgs) for (int i = 0; i < NCH; i++) if (mask[i] && hov[i]) exp_q.push_back(i + LG_OFS);
    chmask = mask; lgsen = lgs; hgovf = hov;
    @(negedge clk); rdo_cmd = 1'b1;
    @(posedge clk); #1; rdo_cmd = 1'b0;
    n_checks++;
    if (!(busy === 1'b1 && ovf_clr === 1'b1 && aborted === 1'b0)) begin
      n_fail++;
      $display("FAIL %s start: busy=%0b ovf_clr=%0b aborted=%0b, required 1 1 0", name, busy, ovf_clr, aborted);
    end
    c = 1; nreq = 0; req_len = 0; req_addr = -1; first_c = 0; done_c = 0; exp_chrd = 0;
    prev_req = 1'b0; ab = 1'b0;
    while (c < 3000) begin
      ch_ack = 1'b0; ch_err = 1'b0; abort_cmd = 1'b0; err_clr = 1'b0;
      fifo_almost_full = (c >= af_from) && (c < af_from + af_len);
      if (ab) begin
        ab = 1'b0;
        n_checks++;
        if (!(ch_req === 1'b0 && done === 1'b1 && aborted === 1'b1)) begin
          n_fail++;
          $display("FAIL %s abort_resp: req=%0b done=%0b aborted=%0b, required 0 1 1", name, ch_req, done, aborted);
        end
      end
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
      if (prev_req && !ch_req && req_addr == noack) begin
        n_checks++;
        if (req_len != TMO) begin
          n_fail++;
          $display("FAIL %s tmo_len: req high %0d cycles, required %0d", name, req_len, TMO);
        end
      end
      if (ch_req === 1'b1) begin
        if (!prev_req) begin
          nreq++;
          req_len  = 0;
          req_addr = int'(ch_addr);
          if (nreq == 1) first_c = c;
          exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          n_checks++;
          if (req_addr != exp_v) begin
            n_fail++;
            $display("FAIL %s addr#%0d: got %0d, required %0d", name, nreq, req_addr, exp_v);
          end
        end
        req_len++;
        if (req_addr == noack) begin
          if (req_len == TMO) begin
            if (clr_on_tmo) begin
              err_clr = 1'b1;
              exp_err = 1;
            end else if (exp_err < ERR_MAX) begin
              exp_err++;
            end
          end
        end else begin
          ch_ack = 1'b1;
          ch_err = err;
          if (nreq == abort_req) begin
            abort_cmd = 1'b1;
            ab = 1'b1;
          end else begin
            exp_chrd++;
            if (err && exp_err < ERR_MAX) exp_err++;
          end
        end
      end
      prev_req = ch_req;
      @(posedge clk); #1;
      c++;
    end
    ch_ack = 1'b0; ch_err = 1'b0; abort_cmd = 1'b0; err_clr = 1'b0; fifo_almost_full = 1'b0;
    n_checks++;
    if (done_c == 0) begin
      n_fail++;
      $display("FAIL %s done_wait: no done within %0d cycles, required done", name, c);
    end
    if (exp_done > 0) begin
      n_checks++;
      if (done_c != exp_done) begin
        n_fail++;
        $display("FAIL %s done_cycle: got %0d, required %0d", name, done_c, exp_done);
      end
    end
    if (exp_first > 0) begin
      n_checks++;
      if (first_c != exp_first) begin
        n_fail++;
        $display("FAIL %s first_req_cycle: got %0d, required %0d", name, first_c, exp_first);
      end
    end
    n_checks++;
    if (int'(chrd_cnt) != exp_chrd || int'(err_cnt) != exp_err || busy !== 1'b0 ||
        aborted !== (abort_req > 0)) begin
      n_fail++;
      $display("FAIL %s end_state: chrd=%0d err=%0d busy=%0b abt=%0b, required chrd=%0d err=%0d busy=0 abt=%0b",
               name, chrd_cnt, err_cnt, busy, aborted, exp_chrd, exp_err, abort_req > 0);
    end
    if (abort_req == 0) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL %s missing_reqs: %0d requests not issued, required 0", name, exp_q.size());
      end
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_hg_pass();
    run_seq("hg_pass", 32'h0000_0005, 1'b0, '0, -1, 1'b0, 0, 0, 0, 1'b0, 2, 1 + NCH + 2);
  endtask

  task automatic test_lg_pass();
    run_seq("lg_pass", 32'h0000_000F, 1'b1, 32'h0000_0002, -1, 1'b0, 0, 0, 0, 1'b0, 2,
            1 + NCH + 4 + NCH + 1);
  endtask

  task automatic test_backpressure();
    run_seq("fifo_af", 32'h0000_0008, 1'b0, '0, -1, 1'b0, 4, 10, 0, 1'b0, 15, 1 + NCH + 1 + 10);
  endtask

  task automatic test_timeout();
    run_seq("timeout", 32'h0000_0006, 1'b0, '0, 1, 1'b0, 0, 0, 0, 1'b0, 3, 1 + NCH + TMO + 1);
  endtask

  task automatic test_abort();
    run_seq("abort", 32'h0000_0001, 1'b0, '0, -1, 1'b0, 0, 0, 1, 1'b0, 2, 3);
    @(negedge clk); rdo_cmd = 1'b1; abort_cmd = 1'b1;
    @(posedge clk); #1; rdo_cmd = 1'b0; abort_cmd = 1'b0;
    n_checks++;
    if (!(busy === 1'b0 && aborted === 1'b1)) begin
      n_fail++;
      $display("FAIL rdo_with_abort: busy=%0b aborted=%0b, required 0 1", busy, aborted);
    end
    run_seq("after_abort", '0, 1'b0, '0, -1, 1'b0, 0, 0, 0, 1'b0, 0, NCH + 1);
  endtask

  task automatic test_err_sat();
    for (int k = 0; k < 8; k++)
      run_seq("err_sat", '1, 1'b0, '0, -1, 1'b1, 0, 0, 0, 1'b0, 2, 1 + 2 * NCH);
  endtask

  task automatic test_err_clr();
    run_seq("clr_on_tmo", 32'h0000_0002, 1'b0, '0, 1, 1'b0, 0, 0, 0, 1'b1, 3, 1 + NCH + TMO);
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    exp_err = 0;
    n_checks++;
    if (int'(err_cnt) != exp_err) begin
      n_fail++;
      $display("FAIL err_clr_alone: err=%0d, required %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_reset_mid();
    chmask = 32'h0000_0001; lgsen = 1'b0;
    @(negedge clk); rdo_cmd = 1'b1;
    @(posedge clk); #1; rdo_cmd = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (!(ch_req === 1'b1 && ch_addr === 7'd0)) begin
      n_fail++;
      $display("FAIL rst_mid_req: req=%0b addr=%0d, required 1 0", ch_req, ch_addr);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_err = 0;
    n_checks++;
    if ({ch_req, ch_addr, ovf_clr, busy, done, aborted, chrd_cnt, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: req=%0b busy=%0b done=%0b abt=%0b chrd=%0d err=%0d, all required 0",
               ch_req, busy, done, aborted, chrd_cnt, err_cnt);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || ch_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_quiet: done=%0b busy=%0b req=%0b, required 0 0 0", done, busy, ch_req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hg_pass();
    test_lg_pass();
    test_backpressure();
    test_timeout();
    test_abort();
    test_err_sat();
    test_err_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
